passcode_encoder: RTL
=====================

# passcode_encoder

Sequential, parametrised successor to the combinational digit encoder. Accepts decimal keypad digits over a valid/ready handshake and encodes each into a 5-bit codeword. Assembles `DIGITS` codewords into one passcode word with backspace and clear editing. Presents the word with a valid/ack handshake to the downstream passcode comparator.

## Interface
- `DIGITS`, default 4: number of digits per passcode; legal range 1..8.
- `MODE`, default 0: selects the per-digit encoding.
  - 0: 2-of-5 code.
  - 1: even-parity binary, `{^d, d}`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `in_valid`  in  1  digit offered.
- `in_digit`  in  4  BCD digit; values 10..15 are illegal.
- `in_ready`  out  1  block accepts a digit this cycle.
- `in_back`  in  1  backspace request, level-sampled each cycle.
- `in_clear`  in  1  clear-all request, level-sampled each cycle.
- `code_out`  out  5*DIGITS  assembled passcode; first digit in the MSBs.
- `code_valid`  out  1  passcode complete.
- `out_ack`  in  1  consumer has taken the passcode.
- `count`  out  $clog2(DIGITS+1)  digits currently held.
- `err`  out  1  one-cycle pulse on an illegal digit.

## Operation
- State machine with two states: ENTRY and FULL. Reset enters ENTRY.
- Reset values: `code_out`=0, `count`=0, `code_valid`=0, `err`=0.
- 2-of-5 table, `[4:0]` weights 7,4,2,1,0:
  - 0→11000, 1→00011, 2→00101, 3→00110, 4→01001
  - 5→01010, 6→01100, 7→10001, 8→10010, 9→10100
- `in_ready` = (state==ENTRY) & !in_back & !in_clear. It is combinational. A digit transfers when in_valid & in_ready.
- Legal digit transfer in ENTRY:
  - `code_out <= {code_out[5*DIGITS-6:0], enc(in_digit)}`.
  - `count <= count+1`.
  - If the new count equals DIGITS, next state is FULL.
- Illegal digit transfer (in_digit>9): the digit is consumed, and `code_out` and `count` are unchanged. `err`=1 for exactly the next cycle.
- Edit priority in ENTRY, per cycle: in_clear > in_back > digit.
  - in_clear: `code_out`=0, `count`=0.
  - in_back with count>0: `code_out >>= 5`, zero-filled at the MSBs, and `count`-1.
  - in_back with count==0: no effect and no err.
- FULL:
  - `code_valid`=1, `in_ready`=0, and `code_out` is held stable.
  - in_back is ignored.
  - out_ack or in_clear: `code_out`=0, `count`=0, next state ENTRY, `code_valid`=0.
  - out_ack and in_clear in the same cycle behave identically to either alone.
- `count` never exceeds DIGITS and never underflows.
- For DIGITS=1 the shift reduces to a direct load.
- Asserting rst_n low at any point, including mid-entry or while in FULL, immediately forces all reset values. There is no partial recovery.

## Timing
- Encoding plus shift takes one cycle: a codeword is visible in `code_out[4:0]` the cycle after the accepting edge.
- `code_valid` rises on the same edge that accepts the final digit, i.e. in the first cycle after that edge. `count` reads DIGITS in that cycle.
- `code_valid` falls on the edge where out_ack=1 is sampled. `in_ready` is 1 again in the following cycle, provided in_back and in_clear are 0.
- Throughput: one digit per cycle in ENTRY.
- Edits (in_back, in_clear) complete in one cycle. Back-to-back backspaces remove one digit per cycle.
- `err` is registered: high for one cycle after each illegal transfer. Consecutive illegal digits give consecutive err cycles.
- Outputs are registered, except `in_ready`.

## Test plan
- Entry, DIGITS=4, MODE=0: enter 1,2,3,4 on consecutive cycles.
  - Required: `code_out`=0x194C9, `count`=4, `code_valid`=1 in the cycle after the 4th accept, `in_ready`=0.
  - Then out_ack=1 for one cycle: `code_out`=0, `count`=0, `code_valid`=0.
- Backspace, DIGITS=4, MODE=0: enter 9,0, then in_back one cycle.
  - Required: `count`=1, `code_out`=0x00014.
  - Then two more in_back cycles: `count`=0, `code_out`=0, err stays 0.
- Illegal digit: enter 5, then in_digit=0xA.
  - Required: err high for exactly one cycle, `count`=1, `code_out`=0x0000A.
  - Then enter 0: `code_out`=0x00158, `count`=2.
- MODE=1, DIGITS=2: enter 7,3.
  - Required: `code_out`=0x2E3, `code_valid`=1.
  - While FULL, in_back and in_valid with 4 are ignored for 3 cycles: `code_out` unchanged.
- Priority collision: in ENTRY with `count`=2, assert in_clear, in_back and in_valid (digit 6) together.
  - Required: `in_ready`=0, next cycle `count`=0, `code_out`=0, no digit stored.
- Reset mid-operation: after 3 of 4 digits, pulse rst_n low asynchronously between clock edges.
  - Required: all outputs go to reset values before the next edge.
  - After release, entering 4 digits completes normally.

Source files
------------

// File: rtl/passcode_encoder.sv
// passcode_encoder
// Accepts BCD keypad digits over a valid/ready handshake, encodes each into a
// 5-bit codeword and assembles DIGITS codewords into one passcode word. The
// word is held, with code_valid high, until the consumer acknowledges it.
// Entry supports backspace and clear-all editing.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_digit  digit offer (BCD; 10..15 are illegal)
//   in_ready            combinational: a digit can be taken this cycle
//   in_back, in_clear   edit requests, level-sampled every cycle
//   code_out            assembled passcode, first digit in the MSBs
//   code_valid          passcode complete, held until out_ack or in_clear
//   out_ack             consumer has taken the passcode
//   count               number of digits currently held
//   err                 one-cycle pulse after an illegal digit is consumed
//
// Parameters:
//   DIGITS  digits per passcode, 1..8
//   MODE    0: 2-of-5 code, 1: even-parity binary {^d, d}
//
// state | meaning
// ------+---------------------------------------------------------------
// ENTRY | collecting digits; edits and digits accepted
// FULL  | DIGITS codewords held; waiting for out_ack or in_clear
module passcode_encoder #(
    parameter int DIGITS = 4,
    parameter int MODE   = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [3:0]                         in_digit,
    output logic                               in_ready,
    input  logic                               in_back,
    input  logic                               in_clear,
    output logic [5*DIGITS-1:0]                code_out,
    output logic                               code_valid,
    input  logic                               out_ack,
    output logic [$clog2(DIGITS+1)-1:0]        count,
    output logic                               err
);

    localparam int W  = 5 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    code_q, code_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count_inc;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    function automatic logic [4:0] enc(input logic [3:0] d);
        logic [4:0] e;
        e = 5'b00000;
        if (MODE == 1) begin
            e = {^d, d};
        end else begin
            case (d)
                4'd0:    e = 5'b11000;
                4'd1:    e = 5'b00011;
                4'd2:    e = 5'b00101;
                4'd3:    e = 5'b00110;
                4'd4:    e = 5'b01001;
                4'd5:    e = 5'b01010;
                4'd6:    e = 5'b01100;
                4'd7:    e = 5'b10001;
                4'd8:    e = 5'b10010;
                4'd9:    e = 5'b10100;
                default: e = 5'b00000;
            endcase
        end
        return e;
    endfunction

    // in_back/in_clear outrank a digit, so they also withdraw ready.
    assign in_ready = (state_q == ENTRY) && !in_back && !in_clear;

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        count_d = count_q;
        err_d   = 1'b0;
        case (state_q)
            ENTRY: begin
                if (in_clear) begin
                    code_d  = '0;
                    count_d = '0;
                end else if (in_back) begin
                    if (count_q != '0) begin
                        code_d  = code_q >> 5;
                        count_d = count_q - 1'b1;
                    end
                end else if (in_valid) begin
                    if (in_digit > 4'd9) begin
                        // Illegal digit is consumed but leaves the word untouched.
                        err_d = 1'b1;
                    end else begin
                        // For DIGITS=1 the shift drops everything: a direct load.
                        code_d  = (code_q << 5) | W'(enc(in_digit));
                        count_d = count_inc;
                        if (count_inc == CW'(DIGITS)) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (out_ack || in_clear) begin
                    code_d  = '0;
                    count_d = '0;
                    state_d = ENTRY;
                end
            end
            default: begin
                state_d = ENTRY;
                code_d  = '0;
                count_d = '0;
            end
        endcase
        valid_d = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            code_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            count_q <= count_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign code_out   = code_q;
    assign count      = count_q;
    assign code_valid = valid_q;
    assign err        = err_q;

endmodule
